// File: rtl/rf_write_scheduler_pkg.sv
// Shared definitions for the register-file write scheduler: default widths
// and the round-robin priority encoding.
package rf_write_scheduler_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 5;

   // Which writeback requester wins when both are valid.
   typedef enum logic {
      PRIO_A = 1'b0,
      PRIO_B = 1'b1
   } prio_t;

endpackage

// File: rtl/rf_write_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter, purely combinational.
// req[0]/gnt[0] is the ALU side, req[1]/gnt[1] the load side.
module rr_arb2
   import rf_write_scheduler_pkg::*;
(
   input  logic [1:0] req,
   input  prio_t      prio,
   output logic [1:0] gnt
);

   // Single requester wins outright; a tie is broken by the pointer.
   always_comb begin
      gnt = '0;
      if (req == 2'b11) begin
         gnt = (prio == PRIO_B) ? 2'b10 : 2'b01;
      end else begin
         gnt = req;
      end
   end

endmodule

// File: rtl/rf_write_scheduler.sv
// Register-file write scheduler: pending-write scoreboard for the issue
// stage plus a round-robin arbitrated single write port shared by the ALU
// and load unit.
module rf_write_scheduler
   import rf_write_scheduler_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_rd,
   output logic              issue_ready,
   input  logic [ADDR_W-1:0] r1,
   input  logic [ADDR_W-1:0] r2,
   output logic              hazard,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_rd,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_rd,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   output logic [ADDR_W-1:0] rd,
   output logic [DATA_W-1:0] rd_data,
   output logic              write_enable,
   output logic              idle
);

   localparam int unsigned NREG = 2 ** ADDR_W;

   logic [NREG-1:0]   pending;
   logic [NREG-1:0]   pend_n;
   prio_t             prio;
   logic [1:0]        gnt;
   logic [ADDR_W-1:0] wr_rd;
   logic [DATA_W-1:0] wr_data;
   logic              write_go;

   rr_arb2 u_arb (
      .req  ({b_valid & ~reset, a_valid & ~reset}),
      .prio (prio),
      .gnt  (gnt)
   );

   assign a_ready = gnt[0];
   assign b_ready = gnt[1];

   // Readiness looks only at registered state, so a write retiring this
   // cycle cannot free the same register for issue until the next cycle.
   assign issue_ready = ~reset & ~pending[issue_rd];
   assign hazard      = ((r1 != '0) & pending[r1]) | ((r2 != '0) & pending[r2]);
   assign idle        = (pending == '0);

   // Select the granted writeback; register 0 is consumed but never written.
   always_comb begin
      wr_rd    = gnt[1] ? b_rd : a_rd;
      wr_data  = gnt[1] ? b_data : a_data;
      write_go = (gnt != '0) && (wr_rd != '0);
   end

   // Next scoreboard: retire the granted write, then add a new reservation.
   always_comb begin
      pend_n = pending;
      if (write_go) begin
         pend_n[wr_rd] = 1'b0;
      end
      if (issue_valid && issue_ready && (issue_rd != '0)) begin
         pend_n[issue_rd] = 1'b1;
      end
      pend_n[0] = 1'b0;
   end

   // Scoreboard, priority pointer and registered write port.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending      <= '0;
         prio         <= PRIO_A;
         write_enable <= 1'b0;
         rd           <= '0;
         rd_data      <= '0;
      end else begin
         pending      <= pend_n;
         write_enable <= write_go;
         if (gnt[0]) begin
            prio <= PRIO_B;
         end else if (gnt[1]) begin
            prio <= PRIO_A;
         end
         if (write_go) begin
            rd      <= wr_rd;
            rd_data <= wr_data;
         end
      end
   end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Self-checking bench for rf_write_scheduler: a reference model predicts
// grants, readiness and the registered write port; expected write-port
// values are queued when stimulus is driven and popped after the edge.
module tb_rf_write_scheduler;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          issue_valid = 1'b0;
   logic [AW-1:0] issue_rd = '0;
   logic          issue_ready;
   logic [AW-1:0] r1 = '0;
   logic [AW-1:0] r2 = '0;
   logic          hazard;
   logic          a_valid = 1'b0;
   logic [AW-1:0] a_rd = '0;
   logic [DW-1:0] a_data = '0;
   logic          a_ready;
   logic          b_valid = 1'b0;
   logic [AW-1:0] b_rd = '0;
   logic [DW-1:0] b_data = '0;
   logic          b_ready;
   logic [AW-1:0] rd;
   logic [DW-1:0] rd_data;
   logic          write_enable;
   logic          idle;

   rf_write_scheduler #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .issue_valid  (issue_valid),
      .issue_rd     (issue_rd),
      .issue_ready  (issue_ready),
      .r1           (r1),
      .r2           (r2),
      .hazard       (hazard),
      .a_valid      (a_valid),
      .a_rd         (a_rd),
      .a_data       (a_data),
      .a_ready      (a_ready),
      .b_valid      (b_valid),
      .b_rd         (b_rd),
      .b_data       (b_data),
      .b_ready      (b_ready),
      .rd           (rd),
      .rd_data      (rd_data),
      .write_enable (write_enable),
      .idle         (idle)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } wr_t;

   wr_t      exp_q[$];
   int       vectors = 0;
   int       miscompares = 0;

   // Reference model state
   logic [31:0]   m_pend = '0;
   logic          m_prio = 1'b0;
   logic [AW-1:0] m_rd = '0;
   logic [DW-1:0] m_data = '0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive, check combinational outputs, predict and check
   // the registered write port after the edge.
   task automatic cycle(input bit rst, input bit iv, input logic [AW-1:0] ird,
                        input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                        input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] adat,
                        input bit bv, input logic [AW-1:0] brd, input logic [DW-1:0] bdat);
      bit            ga, gb, e_ir, e_haz, e_idle;
      logic [AW-1:0] w_rd;
      logic [DW-1:0] w_data;
      logic [31:0]   pend_n;
      wr_t           e, got;
      @(negedge clk);
      reset = rst; issue_valid = iv; issue_rd = ird; r1 = s1; r2 = s2;
      a_valid = av; a_rd = ard; a_data = adat;
      b_valid = bv; b_rd = brd; b_data = bdat;
      #1;
      e_ir   = !rst && !m_pend[ird];
      e_haz  = (s1 != 0 && m_pend[s1]) || (s2 != 0 && m_pend[s2]);
      e_idle = (m_pend == 0);
      if (rst) begin
         ga = 0; gb = 0;
      end else if (av && bv) begin
         ga = (m_prio == 1'b0); gb = !ga;
      end else begin
         ga = av; gb = bv;
      end
      check_val("issue_ready", 64'(issue_ready), 64'(e_ir));
      check_val("hazard", 64'(hazard), 64'(e_haz));
      check_val("idle", 64'(idle), 64'(e_idle));
      check_val("a_ready", 64'(a_ready), 64'(ga));
      check_val("b_ready", 64'(b_ready), 64'(gb));

      w_rd   = gb ? brd : ard;
      w_data = gb ? bdat : adat;
      pend_n = m_pend;
      if (rst) begin
         pend_n = '0; m_prio = 1'b0; m_rd = '0; m_data = '0;
         e = '{we: 1'b0, rd: '0, data: '0};
      end else begin
         if ((ga || gb) && w_rd != 0) begin
            pend_n[w_rd] = 1'b0;
            m_rd = w_rd; m_data = w_data;
            e = '{we: 1'b1, rd: m_rd, data: m_data};
         end else begin
            e = '{we: 1'b0, rd: m_rd, data: m_data};
         end
         if (iv && e_ir && ird != 0) pend_n[ird] = 1'b1;
         if (ga) m_prio = 1'b1;
         else if (gb) m_prio = 1'b0;
      end
      exp_q.push_back(e);

      @(posedge clk);
      #1;
      m_pend = pend_n;
      if (exp_q.size() == 0) begin
         check_val("queue_empty", 64'd1, 64'd0);
      end else begin
         e = exp_q.pop_front();
         got = '{we: write_enable, rd: rd, data: rd_data};
         check_val("write_enable", 64'(got.we), 64'(e.we));
         check_val("rd", 64'(got.rd), 64'(e.rd));
         check_val("rd_data", 64'(got.data), 64'(e.data));
      end
   endtask

   task automatic idle_cycle(input logic [AW-1:0] s1);
      cycle(0, 0, '0, s1, '0, 0, '0, '0, 0, '0, '0);
   endtask

   initial begin
      // Reset state
      cycle(1, 0, '0, '0, '0, 0, '0, '0, 0, '0, '0);
      cycle(1, 0, '0, '0, '0, 0, '0, '0, 0, '0, '0);
      idle_cycle('0);

      // Reserve rd=5, then observe it pending
      cycle(0, 1, 5'd5, '0, '0, 0, '0, '0, 0, '0, '0);
      cycle(0, 1, 5'd5, 5'd5, '0, 0, '0, '0, 0, '0, '0);
      check_val("pend5_set", 64'(idle), 64'd0);

      // ALU write retires rd=5
      cycle(0, 0, '0, 5'd5, '0, 1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
      idle_cycle(5'd5);
      check_val("idle_after_wb", 64'(idle), 64'd1);

      // Contention after reset alternates A,B,A,B
      cycle(1, 0, '0, '0, '0, 0, '0, '0, 0, '0, '0);
      for (int i = 1; i <= 4; i++) begin
         cycle(0, 0, '0, '0, '0, 1, AW'(i), 32'hA000_0000 + 32'(i),
               1, AW'(i), 32'hB000_0000 + 32'(i));
      end
      idle_cycle('0);

      // Write to register 0 is consumed without a write; issue rd=0 reserves nothing
      cycle(0, 1, '0, '0, '0, 0, '0, '0, 1, '0, 32'h1);
      idle_cycle('0);

      // Reset discards a reservation and drops a concurrent request
      cycle(0, 1, 5'd7, '0, '0, 0, '0, '0, 0, '0, '0);
      cycle(1, 0, '0, 5'd7, '0, 1, 5'd7, 32'h7777_7777, 0, '0, '0);
      idle_cycle(5'd7);

      // Reserve and retire rd=9 in the same cycle: no forwarding
      cycle(0, 1, 5'd9, '0, '0, 0, '0, '0, 0, '0, '0);
      cycle(0, 1, 5'd9, 5'd9, '0, 1, 5'd9, 32'h9999_0009, 0, '0, '0);
      cycle(0, 1, 5'd9, 5'd9, '0, 0, '0, '0, 0, '0, '0);
      idle_cycle(5'd9);

      // Randomised traffic over a small register window to force collisions
      for (int i = 0; i < 300; i++) begin
         cycle(($urandom_range(0, 39) == 0),
               bit'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
               AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
               bit'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
               bit'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
